// File: rtl/mips_pkg.sv
// Shared MIPS32 encoding constants, decoded-field bundle and format classifier.
// Pure definitions; no timing or flow-control behaviour.
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_COP0    = 6'b010000;
    localparam logic [5:0] OP_COP1    = 6'b010001;
    localparam logic [5:0] OP_COP2    = 6'b010010;
    localparam logic [5:0] OP_COP3    = 6'b010011;

    localparam logic [1:0] IT_R   = 2'b00;
    localparam logic [1:0] IT_I   = 2'b01;
    localparam logic [1:0] IT_J   = 2'b10;
    localparam logic [1:0] IT_COP = 2'b11;

    localparam int OPC_LSB   = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SA_LSB    = 6;
    localparam int FUNCT_LSB = 0;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  format;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] offset;
        logic [4:0]  base;
        logic [4:0]  sa;
        logic [4:0]  bltz;
        logic [1:0]  i_type;
    } fields_t;

    // REGIMM and any undefined opcode fall through to I-type.
    function automatic logic [1:0] classify(input logic [5:0] op);
        logic [1:0] t;
        t = IT_I;
        case (op)
            OP_SPECIAL:                        t = IT_R;
            OP_J, OP_JAL:                      t = IT_J;
            OP_COP0, OP_COP1, OP_COP2, OP_COP3: t = IT_COP;
            default:                           t = IT_I;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/id_decoder.sv
// Combinational split of an instruction word into MIPS32 fields plus format class.
// Zero latency; no flow control.
module id_decoder
    import mips_pkg::*;
(
    input  logic [31:0] instr_i,
    output fields_t     fields_o
);

    always_comb begin
        fields_o        = '0;
        fields_o.opcode = instr_i[OPC_LSB +: 6];
        fields_o.format = instr_i[RS_LSB +: 5];
        fields_o.funct  = instr_i[FUNCT_LSB +: 6];
        fields_o.rs     = instr_i[RS_LSB +: 5];
        fields_o.rt     = instr_i[RT_LSB +: 5];
        fields_o.rd     = instr_i[RD_LSB +: 5];
        fields_o.imm    = instr_i[15:0];
        fields_o.offset = instr_i[25:0];
        fields_o.base   = instr_i[RS_LSB +: 5];
        fields_o.sa     = instr_i[SA_LSB +: 5];
        fields_o.bltz   = instr_i[RT_LSB +: 5];
        fields_o.i_type = classify(instr_i[OPC_LSB +: 6]);
    end

endmodule

// File: rtl/id_stage.sv
// ID stage: decodes the IF instruction into the ID/EX register, 1-cycle latency.
// A halt from fetch or control loads a NOP bubble (pc still tracks); rs/rt read addresses are combinational.
module id_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [31:0] pc_in,
    input  logic        halt_fetch,
    input  logic        halt_control,
    output logic [5:0]  opcode,
    output logic [4:0]  format,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm,
    output logic [25:0] offset,
    output logic [4:0]  base,
    output logic [4:0]  sa,
    output logic [4:0]  bltz,
    output logic [31:0] pc_out,
    output logic        halt_out,
    output logic [1:0]  i_type,
    output logic [4:0]  rs_reg,
    output logic [4:0]  rt_reg
);

    fields_t     dec;
    fields_t     fields_d, fields_q;
    logic [31:0] pc_q;
    logic        halt_d, halt_q;

    id_decoder u_dec (
        .instr_i  (instruction),
        .fields_o (dec)
    );

    // An all-zero field bundle is exactly sll $0,$0,0 classified as R-type.
    always_comb begin
        halt_d   = halt_fetch | halt_control;
        fields_d = halt_d ? '0 : dec;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fields_q <= '0;
            pc_q     <= '0;
            halt_q   <= 1'b0;
        end else begin
            fields_q <= fields_d;
            pc_q     <= pc_in;
            halt_q   <= halt_d;
        end
    end

    assign opcode   = fields_q.opcode;
    assign format   = fields_q.format;
    assign funct    = fields_q.funct;
    assign rs       = fields_q.rs;
    assign rt       = fields_q.rt;
    assign rd       = fields_q.rd;
    assign imm      = fields_q.imm;
    assign offset   = fields_q.offset;
    assign base     = fields_q.base;
    assign sa       = fields_q.sa;
    assign bltz     = fields_q.bltz;
    assign i_type   = fields_q.i_type;
    assign pc_out   = pc_q;
    assign halt_out = halt_q;

    assign rs_reg = instruction[RS_LSB +: 5];
    assign rt_reg = instruction[RT_LSB +: 5];

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage with hand-computed expectations.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] pc_in;
    logic        halt_fetch;
    logic        halt_control;
    logic [5:0]  opcode;
    logic [4:0]  format;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] offset;
    logic [4:0]  base;
    logic [4:0]  sa;
    logic [4:0]  bltz;
    logic [31:0] pc_out;
    logic        halt_out;
    logic [1:0]  i_type;
    logic [4:0]  rs_reg;
    logic [4:0]  rt_reg;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk          (clk),
        .reset        (reset),
        .instruction  (instruction),
        .pc_in        (pc_in),
        .halt_fetch   (halt_fetch),
        .halt_control (halt_control),
        .opcode       (opcode),
        .format       (format),
        .funct        (funct),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .imm          (imm),
        .offset       (offset),
        .base         (base),
        .sa           (sa),
        .bltz         (bltz),
        .pc_out       (pc_out),
        .halt_out     (halt_out),
        .i_type       (i_type),
        .rs_reg       (rs_reg),
        .rt_reg       (rt_reg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All decoded fields concatenated; a bubble must make this zero.
    function automatic logic [31:0] field_or();
        return 32'(|{opcode, format, funct, rs, rt, rd, imm, offset, base, sa, bltz, i_type});
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic hf, input logic hc);
        @(negedge clk);
        instruction  = ins;
        pc_in        = pc;
        halt_fetch   = hf;
        halt_control = hc;
        #1;
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b0;
        instruction  = 32'h3c1c0000;
        pc_in        = 32'd9996;
        halt_fetch   = 1'b0;
        halt_control = 1'b0;

        // Load something non-zero, then reset asynchronously mid-cycle.
        edge_settle();
        check("pre_reset_opcode", 32'(opcode), 32'h0f);
        #2;
        reset = 1'b1;
        #1;
        check("reset_opcode", 32'(opcode), 32'h0);
        check("reset_rt", 32'(rt), 32'h0);
        check("reset_pc", pc_out, 32'h0);
        check("reset_halt", 32'(halt_out), 32'h0);
        check("reset_itype", 32'(i_type), 32'h0);
        check("reset_rs_reg", 32'(rs_reg), 32'd0);
        check("reset_rt_reg", 32'(rt_reg), 32'd28);
        edge_settle();
        check("reset_hold_pc", pc_out, 32'h0);
        check("reset_hold_fields", field_or(), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // NOP
        drive(32'h00000000, 32'd10000, 1'b0, 1'b0);
        edge_settle();
        check("nop_fields", field_or(), 32'h0);
        check("nop_pc", pc_out, 32'd10000);
        check("nop_halt", 32'(halt_out), 32'h0);

        // LUI: read address visible before the edge
        drive(32'h3c1c0000, 32'd10004, 1'b0, 1'b0);
        check("lui_rt_reg_comb", 32'(rt_reg), 32'd28);
        check("lui_opcode_not_yet", 32'(opcode), 32'h0);
        edge_settle();
        check("lui_opcode", 32'(opcode), 32'b001111);
        check("lui_rs", 32'(rs), 32'h0);
        check("lui_rt", 32'(rt), 32'd28);
        check("lui_imm", 32'(imm), 32'h0);
        check("lui_itype", 32'(i_type), 32'b01);
        check("lui_pc", pc_out, 32'd10004);

        // ADDIU
        drive(32'h279c0000, 32'd10008, 1'b0, 1'b0);
        check("addiu_rs_reg", 32'(rs_reg), 32'd28);
        check("addiu_rt_reg", 32'(rt_reg), 32'd28);
        edge_settle();
        check("addiu_opcode", 32'(opcode), 32'b001001);
        check("addiu_rs", 32'(rs), 32'd28);
        check("addiu_rt", 32'(rt), 32'd28);
        check("addiu_base", 32'(base), 32'd28);
        check("addiu_bltz", 32'(bltz), 32'd28);
        check("addiu_itype", 32'(i_type), 32'b01);
        check("addiu_pc", pc_out, 32'd10008);

        // J, then halt_control bubble, then release
        drive(32'h08000400, 32'd10012, 1'b0, 1'b0);
        edge_settle();
        check("j_opcode", 32'(opcode), 32'b000010);
        check("j_offset", 32'(offset), 32'h400);
        check("j_sa", 32'(sa), 32'd16);
        check("j_itype", 32'(i_type), 32'b10);
        drive(32'h08000400, 32'd10016, 1'b0, 1'b1);
        check("hc_rs_reg_unaffected", 32'(rt_reg), 32'd0);
        edge_settle();
        check("hc_fields", field_or(), 32'h0);
        check("hc_halt", 32'(halt_out), 32'h1);
        check("hc_pc", pc_out, 32'd10016);
        drive(32'h0c000001, 32'd10020, 1'b0, 1'b0);
        edge_settle();
        check("hc_release_halt", 32'(halt_out), 32'h0);
        check("jal_itype", 32'(i_type), 32'b10);
        check("jal_offset", 32'(offset), 32'h1);

        // R-type addu $2,$4,$5, then halt_fetch bubble
        drive(32'h00851021, 32'd10024, 1'b0, 1'b0);
        check("addu_rs_reg", 32'(rs_reg), 32'd4);
        check("addu_rt_reg", 32'(rt_reg), 32'd5);
        edge_settle();
        check("addu_rs", 32'(rs), 32'd4);
        check("addu_rt", 32'(rt), 32'd5);
        check("addu_rd", 32'(rd), 32'd2);
        check("addu_funct", 32'(funct), 32'b100001);
        check("addu_sa", 32'(sa), 32'd0);
        check("addu_itype", 32'(i_type), 32'b00);
        drive(32'h00851021, 32'd10028, 1'b1, 1'b0);
        edge_settle();
        check("hf_fields", field_or(), 32'h0);
        check("hf_halt", 32'(halt_out), 32'h1);
        check("hf_pc", pc_out, 32'd10028);

        // Both halts together
        drive(32'h3c1c0000, 32'd10032, 1'b1, 1'b1);
        edge_settle();
        check("both_fields", field_or(), 32'h0);
        check("both_halt", 32'(halt_out), 32'h1);
        check("both_pc", pc_out, 32'd10032);

        // Format-class boundaries
        drive(32'h46000000, 32'd10036, 1'b0, 1'b0);
        edge_settle();
        check("halt_release2", 32'(halt_out), 32'h0);
        check("cop1_itype", 32'(i_type), 32'b11);
        check("cop1_format", 32'(format), 32'd16);
        drive(32'h4c000000, 32'd10040, 1'b0, 1'b0);
        edge_settle();
        check("cop3_itype", 32'(i_type), 32'b11);
        drive(32'h50000000, 32'd10044, 1'b0, 1'b0);
        edge_settle();
        check("op010100_itype", 32'(i_type), 32'b01);
        drive(32'h04110004, 32'd10048, 1'b0, 1'b0);
        edge_settle();
        check("regimm_itype", 32'(i_type), 32'b01);
        check("regimm_bltz", 32'(bltz), 32'd17);
        check("regimm_imm", 32'(imm), 32'h4);
        drive(32'hfc000000, 32'd10052, 1'b0, 1'b0);
        edge_settle();
        check("undef_itype", 32'(i_type), 32'b01);
        check("undef_opcode", 32'(opcode), 32'h3f);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
